// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, reset PC, FSM encoding and fetch entry type
// Imported by the fetch unit, its buffer and its bus interface.
package fetch_unit_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Sequential successor; wraps naturally at the top of the address space.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode handshakes of the fetch stage
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_instr;

   modport master (
      output imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
   );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - DEPTH-entry FIFO of {pc, instr} with push/pop/flush and count
// Head is read from registered storage, so nothing from push reaches head combinationally.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  fetch_entry_t               push_entry,
   input  logic                       pop,
   input  logic                       flush,
   output fetch_entry_t               head,
   output logic                       head_valid,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   assign head_valid = (count != '0);
   assign head       = mem[rd_ptr];
   assign do_pop     = pop && head_valid;
   assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, request issue, response buffering, redirect
// Outstanding requests keep their addresses in a small queue; redirects convert them to drops.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            jump_flag,
   input  logic [XLEN-1:0] jump_target,
   fetch_unit_if.master    bus,
   output logic            fetch_misalign
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 1;

   logic [0:0]      state;
   logic [XLEN-1:0] pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   buf_count;
   logic [XLEN-1:0] addr_q [BUF_DEPTH];
   logic [PW-1:0]   aq_rd;
   logic [PW-1:0]   aq_wr;
   logic [SW-1:0]   occupancy;
   logic            req_fire;
   logic            rsp_keep;
   logic            redirect;
   logic            head_valid;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

   // Drops still count against capacity so a late response can never find the buffer full.
   assign occupancy = SW'(buf_count) + SW'(outstanding) + SW'(drop_cnt);

   assign bus.imem_req_valid = rst_n && (state == ST_RUN) && !jump_flag
                               && (occupancy < SW'(BUF_DEPTH));
   assign bus.imem_addr      = pc;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
   assign redirect           = jump_flag && (state == ST_RUN);
   assign rsp_keep           = bus.imem_rsp_valid && (drop_cnt == '0) && !jump_flag
                               && (state == ST_RUN);
   assign push_entry         = '{pc: addr_q[aq_rd], instr: bus.imem_rsp_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_RUN;
         pc             <= RESET_PC;
         outstanding    <= '0;
         drop_cnt       <= '0;
         aq_rd          <= '0;
         aq_wr          <= '0;
         fetch_misalign <= 1'b0;
      end else if (redirect) begin
         // A response landing on the redirect edge consumes one of the converted slots.
         drop_cnt    <= drop_cnt + outstanding - CW'(bus.imem_rsp_valid);
         outstanding <= '0;
         aq_rd       <= '0;
         aq_wr       <= '0;
         if (jump_target[1:0] != 2'b00) begin
            state          <= ST_HALT;
            fetch_misalign <= 1'b1;
         end else begin
            pc <= jump_target;
         end
      end else begin
         if (bus.imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         if (req_fire) begin
            pc    <= next_pc(pc);
            aq_wr <= aq_wr + PW'(1);
         end
         if (rsp_keep) aq_rd <= aq_rd + PW'(1);
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) addr_q[aq_wr] <= pc;
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (rsp_keep),
      .push_entry (push_entry),
      .pop        (bus.if_ready),
      .flush      (jump_flag || (state == ST_HALT)),
      .head       (head),
      .head_valid (head_valid),
      .count      (buf_count)
   );

   assign bus.if_valid = head_valid;
   assign bus.if_pc    = head.pc;
   assign bus.if_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
// Memory model with programmable latency; logs of issued requests and decoded pairs.
module tb_fetch_unit;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        jump_flag;
   logic [31:0] jump_target;
   logic        fetch_misalign;

   int n_checks = 0;
   int n_fail   = 0;
   int lat      = 1;
   int ncyc     = 0;

   mreq_t       mq[$];
   logic [31:0] req_log[$];
   logic [31:0] dec_pc[$];
   logic [31:0] dec_instr[$];

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .jump_flag      (jump_flag),
      .jump_target    (jump_target),
      .bus            (bus),
      .fetch_misalign (fetch_misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory and decode observer: runs after the stimulus settles in each cycle.
   always begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
         mq.delete();
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end else begin
         ncyc++;
         if (mq.size() > 0 && mq[0].due <= ncyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(mq[0].addr);
            void'(mq.pop_front());
         end else begin
            bus.imem_rsp_valid = 1'b0;
         end
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            mq.push_back('{addr: bus.imem_addr, due: ncyc + lat});
            req_log.push_back(bus.imem_addr);
         end
         if (bus.if_valid && bus.if_ready) begin
            dec_pc.push_back(bus.if_pc);
            dec_instr.push_back(bus.if_instr);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic apply_reset();
      rst_n       = 1'b0;
      jump_flag   = 1'b0;
      jump_target = '0;
      tick();
      tick();
      req_log.delete();
      dec_pc.delete();
      dec_instr.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; jump_flag = 1'b0; jump_target = '0;
      bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
      tick();
      n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
      n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b expected 0", bus.if_valid); end
      n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", fetch_misalign); end
      apply_reset();
      #1;
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got valid %b addr %h expected 1 00000000", bus.imem_req_valid, bus.imem_addr); end
      tick();
      n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got if_valid %b expected 0", bus.if_valid); end
      tick();
      n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h5A5A_0000) begin n_fail++; $display("FAIL first_if: got %b %h %h expected 1 00000000 5a5a0000", bus.if_valid, bus.if_pc, bus.if_instr); end
   endtask

   task automatic test_sequential();
      repeat (6) tick();
      n_checks++; if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin n_fail++; $display("FAIL seq_addr: got %0d reqs first %h %h %h expected 0 4 8", req_log.size(), req_log[0], req_log[1], req_log[2]); end
      n_checks++; if (dec_pc.size() < 3 || dec_pc[0] !== 32'h0 || dec_pc[1] !== 32'h4 || dec_pc[2] !== 32'h8) begin n_fail++; $display("FAIL seq_pc: got %0d pairs first %h %h %h expected 0 4 8", dec_pc.size(), dec_pc[0], dec_pc[1], dec_pc[2]); end
      n_checks++; if (dec_instr[1] !== 32'h5A5A_0004 || dec_instr[2] !== 32'h5A5A_0008) begin n_fail++; $display("FAIL seq_instr: got %h %h expected 5a5a0004 5a5a0008", dec_instr[1], dec_instr[2]); end
   endtask

   task automatic test_backpressure();
      bus.if_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++; if (req_log.size() - dec_pc.size() > 2) begin n_fail++; $display("FAIL stall_occupancy: got %0d in flight+buffered expected <=2", req_log.size() - dec_pc.size()); end
         if (i >= 3 && bus.if_valid) begin
            n_checks++; if (bus.if_pc !== 32'(4 * dec_pc.size())) begin n_fail++; $display("FAIL stall_head: got %h expected %h", bus.if_pc, 32'(4 * dec_pc.size())); end
         end
      end
      n_checks++; if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_full: got req_valid %b if_valid %b expected 0 1", bus.imem_req_valid, bus.if_valid); end
      bus.if_ready = 1'b1;
      repeat (16) tick();
      n_checks++; if (dec_pc.size() < 8) begin n_fail++; $display("FAIL release_count: got %0d delivered expected >=8", dec_pc.size()); end
      for (int i = 0; i < dec_pc.size(); i++) begin
         n_checks++; if (dec_pc[i] !== 32'(i * 4) || dec_instr[i] !== instr_of(32'(i * 4))) begin n_fail++; $display("FAIL release_order[%0d]: got %h %h expected %h %h", i, dec_pc[i], dec_instr[i], 32'(i * 4), instr_of(32'(i * 4))); end
      end
   endtask

   task automatic test_jump_inflight();
      lat = 3;
      apply_reset();
      tick();
      tick();
      jump_flag = 1'b1; jump_target = 32'h0000_0100;
      #1;
      n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL jump_gates_req: got %b expected 0", bus.imem_req_valid); end
      tick();
      jump_flag = 1'b0;
      #1;
      n_checks++; if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL drop_blocks_req: got req %b if_valid %b expected 0 0", bus.imem_req_valid, bus.if_valid); end
      tick();
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL target_req: got %b %h expected 1 00000100", bus.imem_req_valid, bus.imem_addr); end
      repeat (20) tick();
      n_checks++; if (req_log.size() < 3 || req_log[2] !== 32'h100) begin n_fail++; $display("FAIL inflight_req_log: got %h expected 00000100", req_log[2]); end
      n_checks++; if (dec_pc.size() < 2 || dec_pc[0] !== 32'h100 || dec_pc[1] !== 32'h104) begin n_fail++; $display("FAIL inflight_pc: got %0d pairs %h %h expected 00000100 00000104", dec_pc.size(), dec_pc[0], dec_pc[1]); end
      n_checks++; if (dec_instr[0] !== 32'h5A5A_0100) begin n_fail++; $display("FAIL inflight_instr: got %h expected 5a5a0100", dec_instr[0]); end
   endtask

   task automatic test_jump_collision();
      lat = 1;
      apply_reset();
      tick();
      tick();
      n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin n_fail++; $display("FAIL coll_head: got %b %h expected 1 00000000", bus.if_valid, bus.if_pc); end
      jump_flag = 1'b1; jump_target = 32'h0000_0200;
      tick();
      jump_flag = 1'b0;
      #1;
      n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL coll_flush: got if_valid %b expected 0", bus.if_valid); end
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL coll_req: got %b %h expected 1 00000200", bus.imem_req_valid, bus.imem_addr); end
      repeat (10) tick();
      n_checks++; if (dec_pc.size() < 3 || dec_pc[0] !== 32'h0 || dec_pc[1] !== 32'h200 || dec_pc[2] !== 32'h204) begin n_fail++; $display("FAIL coll_pc: got %0d pairs %h %h %h expected 0 200 204", dec_pc.size(), dec_pc[0], dec_pc[1], dec_pc[2]); end
      n_checks++; if (dec_instr[1] !== 32'h5A5A_0200) begin n_fail++; $display("FAIL coll_instr: got %h expected 5a5a0200", dec_instr[1]); end
   endtask

   task automatic test_misalign();
      lat = 1;
      apply_reset();
      tick();
      tick();
      jump_flag = 1'b1; jump_target = 32'h0000_0102;
      tick();
      jump_flag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (fetch_misalign !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_hold[%0d]: got misalign %b req %b if_valid %b expected 1 0 0", i, fetch_misalign, bus.imem_req_valid, bus.if_valid); end
         tick();
      end
      rst_n = 1'b0;
      #1;
      n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got misalign %b expected 0", fetch_misalign); end
      apply_reset();
      #1;
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL halt_restart: got %b %h expected 1 00000000", bus.imem_req_valid, bus.imem_addr); end
   endtask

   task automatic test_async_reset_wrap();
      lat = 1;
      bus.if_ready = 1'b0;
      repeat (8) tick();
      n_checks++; if (bus.if_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_pre_reset: got if_valid %b req %b expected 1 0", bus.if_valid, bus.imem_req_valid); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL async_clear: got if_valid %b req %b expected 0 0", bus.if_valid, bus.imem_req_valid); end
      bus.if_ready = 1'b1;
      apply_reset();
      #1;
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL post_reset_pc: got %b %h expected 1 00000000", bus.imem_req_valid, bus.imem_addr); end
      tick();
      jump_flag = 1'b1; jump_target = 32'hFFFF_FFFC;
      req_log.delete(); dec_pc.delete(); dec_instr.delete();
      tick();
      jump_flag = 1'b0;
      repeat (8) tick();
      n_checks++; if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_req: got %h %h expected fffffffc 00000000", req_log[0], req_log[1]); end
      n_checks++; if (dec_pc.size() < 2 || dec_pc[0] !== 32'hFFFF_FFFC || dec_pc[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h %h expected fffffffc 00000000", dec_pc[0], dec_pc[1]); end
      n_checks++; if (dec_instr[0] !== 32'hA5A5_FFFC) begin n_fail++; $display("FAIL wrap_instr: got %h expected a5a5fffc", dec_instr[0]); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_jump_inflight();
      test_jump_collision();
      test_misalign();
      test_async_reset_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
